sga_direction_input: RTL and testbench
======================================

Name: sga_direction_input

Overview:
- Front end for the Snake Game Arcade control unit; sits between the four raw direction push-buttons and the controller.
- Synchronizes and debounces each button, then detects press edges.
- Rejects reversal and same-direction presses, commits the snake direction, and emits one `played` pulse per play window.
- Produces the `left`/`right`/`up`/`down`/`played`/`direction` signals the controller consumes while it waits for a move.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable samples required before a debounced level changes (1 ms at 50 MHz).
- CNT_W, 16, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low
- btn_left  in  1  raw button, asynchronous, active-high
- btn_right  in  1  raw button, asynchronous, active-high
- btn_up  in  1  raw button, asynchronous, active-high
- btn_down  in  1  raw button, asynchronous, active-high
- enable  in  1  play window open (driven by controller count_play_time)
- clear_dir  in  1  new game; forces direction to RIGHT
- left, right, up, down  out  1 each  one-cycle pulse naming the accepted command
- played  out  1  one-cycle pulse; a move was accepted in this window
- direction  out  2  committed direction: RIGHT=00, LEFT=01, DOWN=10, UP=11
- db_state  out  2  FSM state for debug: IDLE=0, ARMED=1, ACCEPT=2, HOLD=3

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE; direction=00.
  - All pulses are 0.
  - Synchronizers, debounced levels and counters are cleared to 0.
  - Reset mid-operation aborts any pending event.
- Per button:
  - Input passes through a 2-FF synchronizer.
  - The counter increments while the synchronized value differs from the debounced level and resets to 0 when it matches.
  - When the count reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronized value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are never seen.
- Press event: a 0->1 transition of the debounced level, held as a one-cycle registered flag.
- Simultaneous events in one cycle: a single event is chosen with priority UP > DOWN > LEFT > RIGHT; the others are discarded.
- Candidate direction d is rejected if either holds:
  - d == direction XOR 2'b01 (reversal), or
  - d == direction (no change).
- FSM (registered outputs, Moore):
  - IDLE:
    - enable=1 -> ARMED.
    - Events are discarded.
  - ARMED:
    - enable=0 -> IDLE.
    - Else, an accepted event -> ACCEPT; the candidate is latched.
    - A rejected event stays in ARMED.
  - ACCEPT:
    - Lasts exactly one cycle.
    - direction <= latched candidate.
    - played=1 and the matching direction pulse = 1.
    - -> HOLD.
    - Completes even if enable fell in this cycle.
  - HOLD:
    - enable=0 -> IDLE.
    - Events are discarded: one move per play window.
- Latency: `played` is high in the cycle after the event flag, and 3 + DEBOUNCE_CYCLES cycles after a clean raw rising edge.
- Events are never queued across windows.
- clear_dir:
  - Forces direction=00 in any state and has priority over an ACCEPT commit in the same cycle.
  - The FSM still transitions normally.
  - Pulses in that cycle still fire, but direction ends at 00.
- A button held down produces one event only; a new event needs release then press, each debounced.
- Outputs other than `direction` are 0 outside ACCEPT.

Test Plan:
- Reset: DEBOUNCE_CYCLES=4, drive reset=0 for 2 cycles with all buttons high -> direction=00, db_state=0, no pulses.
- Glitch rejection: enable=1, btn_up high for 3 cycles then low -> no event, played stays 0, direction=00.
- Valid press: enable=1, btn_up held 10 cycles -> exactly one cycle with played=1 and up=1, 7 cycles after the raw edge; direction=11; db_state goes 2 then 3.
- Reversal and no-change: direction=11, then btn_down press -> no pulse, state stays ARMED; btn_up press -> no pulse.
- Simultaneous events: direction=00, btn_up and btn_down rise in the same cycle -> up=1, direction=11; a second press within the same enable window (held through HOLD) -> ignored.
- clear_dir: assert clear_dir on the ACCEPT cycle of a LEFT press from direction=11 -> left=1 and played=1, direction=00 afterward.

Source files
------------

// File: rtl/sga_direction_input.sv
// Snake Game Arcade direction front end: synchronizes and debounces the four
// direction buttons, filters illegal moves and commits one move per play window.

module sga_direction_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;

  // The level only follows the synchronized input after it has disagreed for
  // DEBOUNCE_CYCLES consecutive samples; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

module sga_direction_input #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       enable,
  input  logic       clear_dir,
  output logic       left,
  output logic       right,
  output logic       up,
  output logic       down,
  output logic       played,
  output logic [1:0] direction,
  output logic [1:0] db_state
);

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACCEPT = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cand_q, cand_d;
  logic [1:0] direction_q, direction_d;

  logic levLeft, levRight, levUp, levDown;
  logic evLeft, evRight, evUp, evDown;
  logic       evValid;
  logic [1:0] evDir;
  logic       evReject;

  sga_direction_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_dbLeft (
    .clock(clock), .reset(reset), .raw_i(btn_left), .level_o(levLeft), .rise_o(evLeft)
  );
  sga_direction_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_dbRight (
    .clock(clock), .reset(reset), .raw_i(btn_right), .level_o(levRight), .rise_o(evRight)
  );
  sga_direction_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_dbUp (
    .clock(clock), .reset(reset), .raw_i(btn_up), .level_o(levUp), .rise_o(evUp)
  );
  sga_direction_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_dbDown (
    .clock(clock), .reset(reset), .raw_i(btn_down), .level_o(levDown), .rise_o(evDown)
  );

  // Simultaneous presses collapse to one candidate, UP > DOWN > LEFT > RIGHT.
  always_comb begin
    evValid = evUp | evDown | evLeft | evRight;
    evDir   = DIR_RIGHT;
    if (evUp) begin
      evDir = DIR_UP;
    end else if (evDown) begin
      evDir = DIR_DOWN;
    end else if (evLeft) begin
      evDir = DIR_LEFT;
    end
    evReject = (evDir == (direction_q ^ 2'b01)) || (evDir == direction_q);
  end

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    direction_d = direction_q;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = ARMED;
      end
      ARMED: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (evValid && !evReject) begin
          state_d = ACCEPT;
          cand_d  = evDir;
        end
      end
      ACCEPT: begin
        direction_d = cand_q;
        state_d     = HOLD;
      end
      HOLD: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new game overrides even a commit happening in the same cycle.
    if (clear_dir) direction_d = DIR_RIGHT;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      cand_q      <= DIR_RIGHT;
      direction_q <= DIR_RIGHT;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      direction_q <= direction_d;
    end
  end

  assign played    = (state_q == ACCEPT);
  assign up        = played && (cand_q == DIR_UP);
  assign down      = played && (cand_q == DIR_DOWN);
  assign left      = played && (cand_q == DIR_LEFT);
  assign right     = played && (cand_q == DIR_RIGHT);
  assign direction = direction_q;
  assign db_state  = state_q;

  // Debounced levels are kept for visibility in simulation only.
  logic unusedLevels;
  assign unusedLevels = ^{levLeft, levRight, levUp, levDown};

endmodule

// File: tb/tb_sga_direction_input.sv
// Self-checking bench for sga_direction_input: a queue-based scoreboard of
// expected accepted moves plus directed state checks.

module tb_sga_direction_input;

  localparam logic [3:0] P_UP    = 4'b1000;
  localparam logic [3:0] P_DOWN  = 4'b0100;
  localparam logic [3:0] P_LEFT  = 4'b0010;
  localparam logic [3:0] P_RIGHT = 4'b0001;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic enable = 1'b0, clear_dir = 1'b0;
  logic left, right, up, down, played;
  logic [1:0] direction, db_state;

  typedef struct {
    logic [3:0] pulses;
    logic [1:0] dir;
    int         cycle;
  } expT;

  expT expQ[$];
  int  cycle = 0;
  int  testsRun = 0;
  int  testsFailed = 0;
  bit  dirPending = 1'b0;
  logic [1:0] dirExpected = 2'b00;

  sga_direction_input #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .enable(enable), .clear_dir(clear_dir),
    .left(left), .right(right), .up(up), .down(down),
    .played(played), .direction(direction), .db_state(db_state)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Buttons given as {up, down, left, right}; clearAt selects the hold cycle
  // on which clear_dir is pulsed (-1 for none).
  task automatic applyStimulus(input logic [3:0] btns, input int holdCycles,
                               input bit expectAccept, input logic [3:0] expPulses,
                               input logic [1:0] expDir, input int clearAt);
    expT e;
    {btn_up, btn_down, btn_left, btn_right} = btns;
    if (expectAccept) begin
      e.pulses = expPulses;
      e.dir    = expDir;
      e.cycle  = cycle + 7;
      expQ.push_back(e);
    end
    for (int i = 0; i < holdCycles; i++) begin
      if (expectAccept && i == 7) checkOutput("state_accept", db_state, 2);
      if (expectAccept && i == 8) checkOutput("state_hold", db_state, 3);
      if (i == clearAt) clear_dir = 1'b1;
      tick();
      clear_dir = 1'b0;
    end
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    repeat (10) tick();
  endtask

  // Monitor: pops the scoreboard whenever the DUT announces a move.
  always begin
    @(negedge clock);
    if (reset) begin
      if (dirPending) begin
        checkOutput("committed_dir", direction, dirExpected);
        dirPending = 1'b0;
      end
      if (played) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_played", 1, 0);
        end else begin
          expT e;
          e = expQ.pop_front();
          checkOutput("move_pulses", {up, down, left, right}, e.pulses);
          checkOutput("move_latency_cycle", cycle, e.cycle);
          dirExpected = e.dir;
          dirPending  = 1'b1;
        end
      end else begin
        checkOutput("idle_pulses", {up, down, left, right}, 0);
      end
    end
  end

  initial begin
    // Reset with every button held down.
    {btn_up, btn_down, btn_left, btn_right} = 4'b1111;
    repeat (2) tick();
    checkOutput("reset_direction", direction, 0);
    checkOutput("reset_state", db_state, 0);
    checkOutput("reset_pulses", {up, down, left, right, played}, 0);
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    repeat (2) tick();
    reset = 1'b1;
    tick();

    enable = 1'b1;
    tick();
    checkOutput("armed_after_enable", db_state, 1);

    // Three-sample glitch must be filtered out.
    applyStimulus(P_UP, 3, 1'b0, 4'b0, 2'b00, -1);
    checkOutput("glitch_direction", direction, 0);
    checkOutput("glitch_state", db_state, 1);

    // Clean UP press.
    applyStimulus(P_UP, 10, 1'b1, P_UP, 2'b11, -1);
    checkOutput("up_direction", direction, 3);

    // New window, then reversal (DOWN) and no-change (UP) are refused.
    enable = 1'b0; tick();
    checkOutput("idle_after_window", db_state, 0);
    enable = 1'b1; tick();
    checkOutput("rearmed", db_state, 1);
    applyStimulus(P_DOWN, 10, 1'b0, 4'b0, 2'b00, -1);
    checkOutput("reversal_state", db_state, 1);
    checkOutput("reversal_direction", direction, 3);
    applyStimulus(P_UP, 10, 1'b0, 4'b0, 2'b00, -1);
    checkOutput("nochange_state", db_state, 1);

    // clear_dir alone, then UP and DOWN together from RIGHT.
    clear_dir = 1'b1; tick(); clear_dir = 1'b0;
    checkOutput("clear_direction", direction, 0);
    checkOutput("clear_keeps_state", db_state, 1);
    applyStimulus(P_UP | P_DOWN, 10, 1'b1, P_UP, 2'b11, -1);
    applyStimulus(P_LEFT, 10, 1'b0, 4'b0, 2'b00, -1);
    checkOutput("hold_ignores_press", db_state, 3);
    checkOutput("hold_direction", direction, 3);

    // LEFT accepted from UP, with clear_dir on the ACCEPT cycle.
    enable = 1'b0; tick();
    enable = 1'b1; tick();
    applyStimulus(P_LEFT, 10, 1'b1, P_LEFT, 2'b00, 7);
    checkOutput("clear_wins_direction", direction, 0);

    // From RIGHT: RIGHT refused, then DOWN accepted in the same window.
    enable = 1'b0; tick();
    enable = 1'b1; tick();
    applyStimulus(P_RIGHT, 10, 1'b0, 4'b0, 2'b00, -1);
    checkOutput("right_nochange_state", db_state, 1);
    applyStimulus(P_DOWN, 10, 1'b1, P_DOWN, 2'b10, -1);
    checkOutput("down_direction", direction, 2);

    repeat (3) tick();
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
